timer_seq: RTL and testbench

//  Interval sequencer that drives a TIMER instance's enbl/value inputs and consumes its done pulse.

---
 rtl/timer_seq.sv | 198 +++++++++++++++++++
 tb/tb_timer_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_seq.sv
`default_nettype none
//==============================================================================
// Module      : timer_seq
// Description : Interval sequencer for a TIMER instance. Holds a table of up
//               to DEPTH interval values and plays them back in order, one
//               TIMER run per entry, optionally looping until stopped.
//
// Parameters  : DEPTH - table entries (power of 2, >= 2)
//               VW    - interval value width (matches TIMER value port)
//               AW    - table address width, log2(DEPTH)
//
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               wr_en/wr_addr/wr_data - table write port (any state)
//               len, loop           - pass length / repeat flag, sampled on start
//               start, stop         - single-cycle sequence control pulses
//               tmr_enbl, tmr_value - drive the TIMER enbl / value inputs
//               tmr_done            - TIMER done input
//               busy                - sequence active (LOAD or RUN)
//               step                - index of the current entry
//               step_pulse          - 1-cycle pulse when an entry expires
//               seq_done            - 1-cycle pulse when a non-loop pass ends
//               loop_cnt            - completed-pass counter (optional)
//
// Build option: TIMER_SEQ_LOOPCNT_EN - when defined, adds the loop_cnt
//               output and its saturating 16-bit pass counter.
//
// Revision    : 1.0 - initial release
//==============================================================================
module timer_seq #(
    parameter int DEPTH = 8,
    parameter int VW    = 32,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [VW-1:0] wr_data,
    input  logic [AW:0]   len,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic          tmr_enbl,
    output logic [VW-1:0] tmr_value,
    input  logic          tmr_done,
    output logic          busy,
    output logic [AW-1:0] step,
    output logic          step_pulse,
    output logic          seq_done
`ifdef TIMER_SEQ_LOOPCNT_EN
    ,
    output logic [15:0]   loop_cnt
`endif
);

    localparam logic [1:0]    c_ST_IDLE   = 2'd0;
    localparam logic [1:0]    c_ST_LOAD   = 2'd1;
    localparam logic [1:0]    c_ST_RUN    = 2'd2;
    localparam logic [AW:0]   c_DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] c_STEP_ONE  = AW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_step;
    logic [AW:0]   r_len;
    logic          r_loop;
    logic [VW-1:0] r_tmr_value;
    logic          r_step_pulse;
    logic          r_seq_done;
    logic [VW-1:0] r_table [DEPTH];

    logic          w_start_ok;
    logic          w_expire;
    logic          w_last;
    logic [AW:0]   w_len_clamp;

    // stop dominates both start and tmr_done
    assign w_start_ok  = start && !stop && (len != '0);
    assign w_expire    = (r_state == c_ST_RUN) && tmr_done && !stop;
    assign w_last      = (({1'b0, r_step} + c_LEN_ONE) == r_len);
    assign w_len_clamp = (len > c_DEPTH_LEN) ? c_DEPTH_LEN : len;

    // Interval table: not reset; a write to the running entry is only seen
    // at that entry's next LOAD because tmr_value is a registered copy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = stop ? c_ST_IDLE : c_ST_RUN;
            end
            c_ST_RUN: begin
                if (stop) begin
                    w_next_state = c_ST_IDLE;
                end else if (tmr_done) begin
                    w_next_state = (w_last && !r_loop) ? c_ST_IDLE : c_ST_LOAD;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; enbl follows the state register so an async
    // reset drops it immediately, and LOAD gives the TIMER one low cycle.
    always_comb begin
        tmr_enbl = (r_state == c_ST_RUN);
        busy     = (r_state != c_ST_IDLE);
    end

    // Step index, latched pass configuration, value register, pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
            r_tmr_value  <= '0;
            r_step_pulse <= 1'b0;
            r_seq_done   <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_seq_done   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_ok) begin
                        r_step <= '0;
                        r_len  <= w_len_clamp;
                        r_loop <= loop;
                    end
                end
                c_ST_LOAD: begin
                    r_tmr_value <= r_table[r_step];
                end
                c_ST_RUN: begin
                    if (w_expire) begin
                        r_step_pulse <= 1'b1;
                        if (!w_last) begin
                            r_step <= r_step + c_STEP_ONE;
                        end else if (r_loop) begin
                            r_step <= '0;
                        end else begin
                            // step keeps the last index after a finished pass
                            r_seq_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign step       = r_step;
    assign tmr_value  = r_tmr_value;
    assign step_pulse = r_step_pulse;
    assign seq_done   = r_seq_done;

`ifdef TIMER_SEQ_LOOPCNT_EN
    logic [15:0] r_loop_cnt;

    // Counts final-entry expiries in loop and non-loop mode, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loop_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) && w_start_ok) begin
            r_loop_cnt <= '0;
        end else if (w_expire && w_last && (r_loop_cnt != 16'hFFFF)) begin
            r_loop_cnt <= r_loop_cnt + 16'd1;
        end
    end

    assign loop_cnt = r_loop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_timer_seq
// Description : Self-checking bench for timer_seq. A small TIMER model
//               answers done after tmr_value enabled cycles (or done is
//               driven by hand); entries seen at each enbl rise are matched
//               against an expected-entry queue.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_timer_seq;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] val;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, loop, start, stop, man_done, auto_mode;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  len;
    logic        tmr_enbl, tmr_done, busy, step_pulse, seq_done;
    logic [31:0] tmr_value;
    logic [2:0]  step;
    logic [31:0] tcnt;
`ifdef TIMER_SEQ_LOOPCNT_EN
    logic [15:0] loop_cnt;
`endif

    ent_t exp_q[$];
    ent_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_sp, n_sd;
    int   n_wide   = 0;
    logic prev_enbl = 1'b0, prev_sp = 1'b0, prev_sd = 1'b0;

    always #5 clk = ~clk;

    timer_seq #(.DEPTH(8), .VW(32), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len        (len),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .tmr_enbl   (tmr_enbl),
        .tmr_value  (tmr_value),
        .tmr_done   (tmr_done),
        .busy       (busy),
        .step       (step),
        .step_pulse (step_pulse),
        .seq_done   (seq_done)
`ifdef TIMER_SEQ_LOOPCNT_EN
        ,
        .loop_cnt   (loop_cnt)
`endif
    );

    // TIMER model: done on the tmr_value-th enabled cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= 32'd0;
        else        tcnt <= tmr_enbl ? tcnt + 32'd1 : 32'd0;
    end
    assign tmr_done = auto_mode ? (tmr_enbl && ((tcnt + 32'd1) == tmr_value)) : man_done;

    // Advance one clock and sample outputs on the falling edge
    task automatic tick();
        @(negedge clk);
        if (tmr_enbl && !prev_enbl) obs_q.push_back('{st: step, val: tmr_value});
        prev_enbl = tmr_enbl;
        if (step_pulse) n_sp++;
        if (seq_done) n_sd++;
        if ((step_pulse && prev_sp) || (seq_done && prev_sd)) n_wide++;
        prev_sp = step_pulse;
        prev_sd = seq_done;
    endtask

    task automatic clr();
        n_sp = 0; n_sd = 0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 32'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int l, input logic lp);
        len = 4'(l); loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic push(input int s, input int v);
        exp_q.push_back('{st: 3'(s), val: 32'(v)});
    endtask

    task automatic wait_obs(input int n, input string nm);
        int g = 0;
        while (obs_q.size() < n && g < 400) begin tick(); g++; end
        if (obs_q.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: saw %0d entries, want %0d", nm, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (tmr_enbl !== 1'b0) begin n_fail++; $display("FAIL reset_enbl: got %0b want 0", tmr_enbl); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL reset_step: got %0d want 0", step); end
        n_checks++; if (tmr_value !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", tmr_value); end
        n_checks++; if ({step_pulse, seq_done} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {step_pulse, seq_done}); end
`ifdef TIMER_SEQ_LOOPCNT_EN
        n_checks++; if (loop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_loop_cnt: got %0d want 0", loop_cnt); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        int bc;
        ent_t e, o;
        clr();
        wr(0, 5); wr(1, 3); wr(2, 7);
        push(0, 5); push(1, 3); push(2, 7);
        pulse_start(3, 1'b0);
        n_checks++; if ({busy, tmr_enbl} !== 2'b10) begin n_fail++; $display("FAIL sp_load: busy/enbl got %b want 10", {busy, tmr_enbl}); end
        tick();
        n_checks++; if (tmr_enbl !== 1'b1) begin n_fail++; $display("FAIL sp_start_latency: enbl got %0b want 1", tmr_enbl); end
        // LOAD+5 + LOAD+3 + LOAD+7 busy cycles
        bc = 2;
        while (busy && bc < 200) begin tick(); if (busy) bc++; end
        n_checks++; if (bc !== 18) begin n_fail++; $display("FAIL sp_busy_cycles: got %0d want 18", bc); end
        n_checks++; if (seq_done !== 1'b1) begin n_fail++; $display("FAIL sp_seq_done_at_idle: got %0b want 1", seq_done); end
        n_checks++; if (n_sp !== 3) begin n_fail++; $display("FAIL sp_step_pulses: got %0d want 3", n_sp); end
        n_checks++; if (n_sd !== 1) begin n_fail++; $display("FAIL sp_seq_done_count: got %0d want 1", n_sd); end
        n_checks++; if (step !== 3'd2) begin n_fail++; $display("FAIL sp_final_step: got %0d want 2", step); end
        n_checks++; if (tmr_value !== 32'd7) begin n_fail++; $display("FAIL sp_value_hold: got %0d want 7", tmr_value); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL sp_sb: no entry, want step %0d value %0d", e.st, e.val); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL sp_sb: got step %0d value %0d want step %0d value %0d", o.st, o.val, e.st, e.val); end
            end
        end
    endtask

    task automatic test_loop_stop();
        ent_t e, o;
        clr();
        push(0, 5); push(1, 3); push(2, 7); push(0, 5); push(1, 3);
        pulse_start(3, 1'b1);
        wait_obs(5, "loop");
        tick();
        pulse_stop();
        n_checks++; if ({busy, tmr_enbl, step_pulse} !== 3'b000) begin n_fail++; $display("FAIL loop_stop: busy/enbl/pulse got %b want 000", {busy, tmr_enbl, step_pulse}); end
        repeat (5) tick();
        n_checks++; if (n_sp !== 4) begin n_fail++; $display("FAIL loop_step_pulses: got %0d want 4", n_sp); end
        n_checks++; if (n_sd !== 0) begin n_fail++; $display("FAIL loop_no_seq_done: got %0d want 0", n_sd); end
        n_checks++; if (tmr_enbl !== 1'b0) begin n_fail++; $display("FAIL loop_enbl_after_stop: got %0b want 0", tmr_enbl); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL loop_sb: no entry, want step %0d value %0d", e.st, e.val); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL loop_sb: got step %0d value %0d want step %0d value %0d", o.st, o.val, e.st, e.val); end
            end
        end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL loop_extra_entries: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_len_edges();
        int g;
        logic [2:0] s;
        ent_t e, o;
        clr();
        s = step;
        pulse_start(0, 1'b0);
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %0b want 0", busy); end
        n_checks++; if (step !== s) begin n_fail++; $display("FAIL len0_step: got %0d want %0d", step, s); end
        for (int i = 0; i < 8; i++) begin wr(i, 2 + i); push(i, 2 + i); end
        pulse_start(12, 1'b0);
        g = 0;
        while (busy && g < 400) begin tick(); g++; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len12_timeout: busy got %0b want 0", busy); end
        n_checks++; if (n_sp !== 8) begin n_fail++; $display("FAIL len12_step_pulses: got %0d want 8", n_sp); end
        n_checks++; if (n_sd !== 1) begin n_fail++; $display("FAIL len12_seq_done: got %0d want 1", n_sd); end
        n_checks++; if (step !== 3'd7) begin n_fail++; $display("FAIL len12_final_step: got %0d want 7", step); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL len12_sb: no entry, want step %0d value %0d", e.st, e.val); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL len12_sb: got step %0d value %0d want step %0d value %0d", o.st, o.val, e.st, e.val); end
            end
        end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL len12_extra_entries: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_collisions();
        clr();
        auto_mode = 1'b0; man_done = 1'b0;
        pulse_start(3, 1'b0);
        tick();
        n_checks++; if (tmr_enbl !== 1'b1) begin n_fail++; $display("FAIL col_run: enbl got %0b want 1", tmr_enbl); end
        man_done = 1'b1; tick(); man_done = 1'b0;
        n_checks++; if ({step_pulse, tmr_enbl, step} !== {1'b1, 1'b0, 3'd1}) begin n_fail++; $display("FAIL col_done_response: pulse/enbl/step got %b/%b/%0d want 1/0/1", step_pulse, tmr_enbl, step); end
        tick();
        n_checks++; if ({tmr_enbl, tmr_value} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL col_done_latency: enbl/value got %b/%0d want 1/3", tmr_enbl, tmr_value); end
        pulse_start(4, 1'b1);
        n_checks++; if ({busy, tmr_enbl, step} !== {1'b1, 1'b1, 3'd1}) begin n_fail++; $display("FAIL col_start_busy: busy/enbl/step got %b/%b/%0d want 1/1/1", busy, tmr_enbl, step); end
        man_done = 1'b1; stop = 1'b1; tick(); man_done = 1'b0; stop = 1'b0;
        n_checks++; if ({step_pulse, busy, step} !== {1'b0, 1'b0, 3'd1}) begin n_fail++; $display("FAIL col_stop_done: pulse/busy/step got %b/%b/%0d want 0/0/1", step_pulse, busy, step); end
        tick();
        n_checks++; if ({n_sp, n_sd} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL col_pulse_counts: step_pulse %0d seq_done %0d want 1 and 0", n_sp, n_sd); end
        stop = 1'b1; pulse_start(3, 1'b0); stop = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL col_stop_start_idle: busy got %0b want 0", busy); end
        auto_mode = 1'b1;
    endtask

    task automatic test_write_running();
        ent_t e, o;
        clr();
        wr(0, 5); wr(1, 3); wr(2, 7);
        push(0, 5); push(1, 3); push(2, 7); push(0, 5); push(1, 9);
        pulse_start(3, 1'b1);
        wait_obs(2, "wrun");
        wr(1, 9);
        n_checks++; if ({tmr_enbl, tmr_value} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL wrun_current_value: enbl/value got %b/%0d want 1/3", tmr_enbl, tmr_value); end
        wait_obs(5, "wrun");
        pulse_stop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL wrun_sb: no entry, want step %0d value %0d", e.st, e.val); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL wrun_sb: got step %0d value %0d want step %0d value %0d", o.st, o.val, e.st, e.val); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        clr();
        wr(1, 3);
        pulse_start(3, 1'b1);
        wait_obs(2, "rmid");
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({tmr_enbl, busy, step} !== {1'b0, 1'b0, 3'd0}) begin n_fail++; $display("FAIL rmid_async: enbl/busy/step got %b/%b/%0d want 0/0/0", tmr_enbl, busy, step); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({busy, step_pulse, seq_done} !== 3'b000) begin n_fail++; $display("FAIL rmid_after: busy/pulse/done got %b want 000", {busy, step_pulse, seq_done}); end
    endtask

`ifdef TIMER_SEQ_LOOPCNT_EN
    task automatic test_loop_cnt();
        clr();
        pulse_start(3, 1'b1);
        wait_obs(10, "lcnt");
        n_checks++; if (loop_cnt !== 16'd3) begin n_fail++; $display("FAIL lcnt_three: got %0d want 3", loop_cnt); end
        pulse_stop();
        pulse_start(3, 1'b0);
        n_checks++; if (loop_cnt !== 16'd0) begin n_fail++; $display("FAIL lcnt_clear: got %0d want 0", loop_cnt); end
        pulse_stop();
    endtask
`endif

    task automatic test_pulse_width();
        n_checks++; if (n_wide !== 0) begin n_fail++; $display("FAIL pulse_width: %0d multi-cycle pulses, want 0", n_wide); end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
        len = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        man_done = 1'b0; auto_mode = 1'b1;
        n_sp = 0; n_sd = 0;
        test_reset();
        test_single_pass();
        test_loop_stop();
        test_len_edges();
        test_collisions();
        test_write_running();
        test_reset_midrun();
`ifdef TIMER_SEQ_LOOPCNT_EN
        test_loop_cnt();
`endif
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
